// File: rtl/arith_pkg.sv
// Shared types for the byte-serial add/subtract sequencer.
// Holds op codes, FSM states and the slice-index width helper.
package arith_pkg;

  typedef enum logic [1:0] {
    ADD  = 2'b00,
    SUB  = 2'b01,
    NEG  = 2'b10,
    RSUB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic int idx_w(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

endpackage

// File: rtl/slice_adder_ci.sv
// N-bit ripple slice adder with external carry-in and carry-out,
// built from single-bit full-adder cells.
module single_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);

  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));

endmodule

module slice_adder_ci #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_ci,
  output logic [N-1:0] o_s,
  output logic         o_co
);

  logic [N:0] w_c;

  assign w_c[0] = i_ci;

  for (genvar g = 0; g < N; g++) begin : g_bit
    single_adder u_fa (
      .i_a  (i_a[g]),
      .i_b  (i_b[g]),
      .i_ci (w_c[g]),
      .o_s  (o_s[g]),
      .o_co (w_c[g+1])
    );
  end

  assign o_co = w_c[N];

endmodule

// File: rtl/multibyte_add_seq.sv
// Byte-serial multi-precision add/sub controller: walks one N-bit
// slice adder across BYTES slices, LSB first, with a registered carry.
module multibyte_add_seq
  import arith_pkg::*;
#(
  parameter int N     = 8,
  parameter int BYTES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [N*BYTES-1:0] req_a,
  input  logic [N*BYTES-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [N*BYTES-1:0] rsp_sum,
  output logic               rsp_carry,
  output logic               rsp_ovf,
  output logic               rsp_zero,
  output logic               busy
);

  localparam int WIDE = N * BYTES;
  localparam int IW   = idx_w(BYTES);
  localparam logic [IW-1:0] LAST = IW'(BYTES - 1);

  state_e r_state;
  state_e w_state_nxt;

  logic [IW-1:0]   r_idx;
  logic            r_carry;
  logic [WIDE-1:0] r_x;
  logic [WIDE-1:0] r_y;
  logic [WIDE-1:0] r_sum;
  logic            r_cout;
  logic            r_ovf;
  logic            r_zero;

  logic [WIDE-1:0] w_x;
  logic [WIDE-1:0] w_y;
  logic            w_cin;
  logic [N-1:0]    w_xs;
  logic [N-1:0]    w_ys;
  logic [N-1:0]    w_s;
  logic            w_co;
  logic [WIDE-1:0] w_sum_nxt;
  logic            w_acc;
  logic            w_last;

  // Map every op onto X + Y + Cin so the datapath only ever adds.
  always_comb begin
    w_x   = req_a;
    w_y   = req_b;
    w_cin = 1'b0;
    unique case (1'b1)
      (req_op == ADD): begin
        w_x   = req_a;
        w_y   = req_b;
        w_cin = 1'b0;
      end
      (req_op == SUB): begin
        w_x   = req_a;
        w_y   = ~req_b;
        w_cin = 1'b1;
      end
      (req_op == NEG): begin
        w_x   = '0;
        w_y   = ~req_a;
        w_cin = 1'b1;
      end
      (req_op == RSUB): begin
        w_x   = req_b;
        w_y   = ~req_a;
        w_cin = 1'b1;
      end
      default: begin
        w_x   = req_a;
        w_y   = req_b;
        w_cin = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_xs = '0;
    w_ys = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (r_idx == IW'(i)) begin
        w_xs = r_x[i*N +: N];
        w_ys = r_y[i*N +: N];
      end
    end
  end

  slice_adder_ci #(
    .N (N)
  ) u_add (
    .i_a  (w_xs),
    .i_b  (w_ys),
    .i_ci (r_carry),
    .o_s  (w_s),
    .o_co (w_co)
  );

  always_comb begin
    w_sum_nxt = r_sum;
    for (int i = 0; i < BYTES; i++) begin
      if (r_idx == IW'(i)) begin
        w_sum_nxt[i*N +: N] = w_s;
      end
    end
  end

  assign w_acc  = (r_state == IDLE) && req_valid;
  assign w_last = (r_idx == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    busy        = (r_state != IDLE);
    unique case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_acc) begin
      r_x     <= w_x;
      r_y     <= w_y;
      r_carry <= w_cin;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_sum   <= w_sum_nxt;
      r_carry <= w_co;
      r_idx   <= r_idx + IW'(1);
      if (w_last) begin
        r_cout <= w_co;
        r_ovf  <= (r_x[WIDE-1] == r_y[WIDE-1]) &&
                  (w_sum_nxt[WIDE-1] != r_x[WIDE-1]);
        r_zero <= ~|w_sum_nxt;
      end
    end
  end

  assign rsp_sum   = r_sum;
  assign rsp_carry = r_cout;
  assign rsp_ovf   = r_ovf;
  assign rsp_zero  = r_zero;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Randomized bench for multibyte_add_seq against a signed/unsigned
// arithmetic reference of the four ops.
module tb_multibyte_add_seq;

  localparam int N     = 8;
  localparam int BYTES = 2;
  localparam int WIDE  = N * BYTES;

  logic            clk;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic [WIDE-1:0] req_a;
  logic [WIDE-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [WIDE-1:0] rsp_sum;
  logic            rsp_carry;
  logic            rsp_ovf;
  logic            rsp_zero;
  logic            busy;

  int errs;
  int checks;

  multibyte_add_seq #(
    .N     (N),
    .BYTES (BYTES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .rsp_ovf   (rsp_ovf),
    .rsp_zero  (rsp_zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {zero, ovf, carry, sum} from plain integer arithmetic.
  function automatic logic [WIDE+2:0] ref_op(input logic [1:0] op,
                                              input logic [WIDE-1:0] a,
                                              input logic [WIDE-1:0] b);
    longint ua, ub, ur, sa, sb, sr;
    logic [WIDE-1:0] s;
    logic c, ov;
    ua = longint'(a);
    ub = longint'(b);
    sa = (a[WIDE-1]) ? ua - (64'sd1 <<< WIDE) : ua;
    sb = (b[WIDE-1]) ? ub - (64'sd1 <<< WIDE) : ub;
    case (op)
      2'd0: begin ur = ua + ub; c = (ur >= (64'sd1 <<< WIDE)); sr = sa + sb; end
      2'd1: begin ur = ua - ub; c = (ua >= ub);               sr = sa - sb; end
      2'd2: begin ur = -ua;     c = (ua == 0);                sr = -sa;     end
      default: begin ur = ub - ua; c = (ub >= ua);            sr = sb - sa; end
    endcase
    s  = WIDE'(ur);
    ov = (sr >= (64'sd1 <<< (WIDE - 1))) || (sr < -(64'sd1 <<< (WIDE - 1)));
    return {(s == '0), ov, c, s};
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [WIDE-1:0] a,
                        input logic [WIDE-1:0] b, input int hold);
    logic [WIDE+2:0] e;
    int n;
    e = ref_op(op, a, b);
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk); #1;
    // Junk request held during RUN/DONE must be neither taken nor mixed in.
    req_op = 2'($urandom_range(0, 3));
    req_a  = WIDE'($urandom);
    req_b  = WIDE'($urandom);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1; n++;
      req_a = WIDE'($urandom);
    end
    check("latency", n, BYTES);
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", rsp_valid, 1);
      check("hold_rdy", req_ready, 0);
      check("hold_busy", busy, 1);
      check("hold_sum", rsp_sum, e[WIDE-1:0]);
      @(posedge clk); #1;
    end
    check("sum", rsp_sum, e[WIDE-1:0]);
    check("carry", rsp_carry, e[WIDE]);
    check("ovf", rsp_ovf, e[WIDE+1]);
    check("zero", rsp_zero, e[WIDE+2]);
    check("valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_valid", rsp_valid, 0);
    check("idle_rdy", req_ready, 1);
  endtask

  initial begin
    logic [WIDE-1:0] ra, rb;
    errs      = 0;
    checks    = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'd0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", req_ready, 1);
    check("rst_valid", rsp_valid, 0);
    check("rst_sum", rsp_sum, 0);
    check("rst_flags", {rsp_carry, rsp_ovf, rsp_zero}, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(2'd0, 16'h00FF, 16'h0001, 0);
    run_op(2'd0, 16'hFFFF, 16'h0001, 0);
    run_op(2'd0, 16'h7FFF, 16'h0001, 0);
    run_op(2'd1, 16'h0000, 16'h0001, 0);
    run_op(2'd2, 16'h8000, 16'h1234, 0);
    run_op(2'd3, 16'h0003, 16'h0010, 0);
    run_op(2'd2, 16'h0000, 16'h0000, 1);
    run_op(2'd1, 16'h8000, 16'h0001, 2);
    run_op(2'd0, 16'h1234, 16'h4321, 5);

    // Reset while the second slice is in flight.
    req_valid = 1'b1;
    req_op    = 2'd0;
    req_a     = 16'hFFFF;
    req_b     = 16'h00FF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mrst_sum", rsp_sum, 0);
    check("mrst_valid", rsp_valid, 0);
    check("mrst_rdy", req_ready, 1);
    check("mrst_busy", busy, 0);
    check("mrst_flags", {rsp_carry, rsp_ovf, rsp_zero}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mrst_novalid", rsp_valid, 0);
    run_op(2'd0, 16'h0001, 16'h0001, 0);

    for (int i = 0; i < 60; i++) begin
      ra = WIDE'($urandom);
      rb = WIDE'($urandom);
      if ($urandom_range(0, 5) == 0) ra = 16'h8000;
      if ($urandom_range(0, 5) == 0) rb = ra;
      if ($urandom_range(0, 7) == 0) rb = 16'hFFFF;
      run_op(2'($urandom_range(0, 3)), ra, rb, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
